serial_addsub_seq: RTL and testbench

- Multi-cycle controller that performs WIDTH-bit add/subtract, where WIDTH = 4*NIBBLES, by time-multiplexing one 4-bit ripple-carry add/sub slice over successive nibbles, LSB nibble first.
- Holds the carry in a flop between nibble steps.
- Captures operands through a start/busy/done handshake.
- Sits between the ALU control logic and the arithmetic slice, so the ALU can do wide arithmetic without a wide adder.

---
 rtl/serial_addsub_seq.sv | 138 +++++++++++++
 tb/tb_serial_addsub_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_seq.sv
// Wide add/subtract built from one 4-bit ripple slice stepped LSB nibble first.
// start/busy/done handshake; result, cout and overflow are registered.
module serial_addsub_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   overflow
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_op;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_result;
    logic            r_cout;
    logic            r_ovf;

    logic [3:0]      w_x;
    logic [3:0]      w_y;
    logic [3:0]      w_sum;
    logic [4:0]      w_c;
    logic            w_last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            S_IDLE:  ;
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_last = (r_idx == LAST);

    // One 4-bit ripple slice; B inverted by the captured op, not the carry
    always_comb begin
        w_x    = r_a[4*r_idx +: 4];
        w_y    = r_b[4*r_idx +: 4] ^ {4{r_op}};
        w_c    = '0;
        w_sum  = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_sum[i]  = w_x[i] ^ w_y[i] ^ w_c[i];
            w_c[i+1]  = (w_x[i] & w_y[i]) | (w_c[i] & (w_x[i] ^ w_y[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op_sub;
                        r_carry <= op_sub;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_result[4*r_idx +: 4] <= w_sum;
                    r_carry                <= w_c[4];
                    if (w_last) begin
                        r_cout <= w_c[4];
                        r_ovf  <= w_c[4] ^ w_c[3];
                    end else begin
                        r_idx  <= r_idx + IW'(1);
                    end
                end
                S_DONE:  ;
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Bench for serial_addsub_seq: directed handshake/reset cases at NIBBLES=4,
// random add/sub at NIBBLES=2, 4 and 8 against an arithmetic model.
module tb_serial_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        s2, o2, busy2, done2, cout2, ov2;
    logic [7:0]  a2, b2, res2;
    logic        s4, o4, busy4, done4, cout4, ov4;
    logic [15:0] a4, b4, res4;
    logic        s8, o8, busy8, done8, cout8, ov8;
    logic [31:0] a8, b8, res8;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_addsub_seq #(.NIBBLES(2)) u2 (
        .clk(clk), .rst(rst), .start(s2), .op_sub(o2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2),
        .overflow(ov2)
    );

    serial_addsub_seq #(.NIBBLES(4)) u4 (
        .clk(clk), .rst(rst), .start(s4), .op_sub(o4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4),
        .overflow(ov4)
    );

    serial_addsub_seq #(.NIBBLES(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .op_sub(o8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8),
        .overflow(ov8)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed {result, cout, overflow} from plain integer arithmetic
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic op);
        longint m, h, ua, ub, r, sa, sb, s;
        logic   c, v;
        m  = longint'(1) << w;
        h  = m / 2;
        ua = longint'(a);
        ub = longint'(b);
        if (op) begin
            r = ua - ub;
            c = (ua >= ub);
        end else begin
            r = ua + ub;
            c = (r >= m);
        end
        if (r < 0) r = r + m;
        r  = r % m;
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        s  = op ? sa - sb : sa + sb;
        v  = (s < -h) || (s >= h);
        return (64'(r) << 2) | {62'd0, c, v};
    endfunction

    // Start on the next edge; done must appear 5 edges after the edge
    // preceding the start request
    task automatic op4(input logic [15:0] a, input logic [15:0] b,
                       input logic op, input logic [17:0] exp,
                       input string tag);
        s4 = 1'b1; a4 = a; b4 = b; o4 = op;
        step;
        s4 = 1'b0; a4 = ~a; b4 = ~b; o4 = ~op;
        chk({tag, " busy"}, 64'(busy4), 64'(1));
        for (int i = 2; i <= 5; i++) begin
            step;
            chk({tag, " done"}, 64'(done4), 64'(i == 5));
        end
        chk({tag, " res"}, 64'({res4, cout4, ov4}), 64'(exp));
        step;
        chk({tag, " done off"}, 64'(done4), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         q[$];
        int         nd;
        logic [17:0] seen;
        logic       g2, g4, g8;
        logic [7:0]  ra2, rb2;
        logic [15:0] ra4, rb4;
        logic [31:0] ra8, rb8;
        logic       ro2, ro4, ro8;

        rst = 1'b1;
        s2 = 0; o2 = 0; a2 = '0; b2 = '0;
        s4 = 0; o4 = 0; a4 = '0; b4 = '0;
        s8 = 0; o8 = 0; a8 = '0; b8 = '0;
        step;
        step;
        chk("rst busy", 64'(busy4), 64'(0));
        chk("rst done", 64'(done4), 64'(0));
        chk("rst out4", 64'({res4, cout4, ov4}), 64'(0));
        chk("rst out8", 64'({res8, cout8, ov8}), 64'(0));
        rst = 1'b0;
        step;

        op4(16'h1234, 16'h0FFF, 1'b0, {16'h2233, 1'b0, 1'b0}, "add");
        op4(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1}, "add ovf");
        op4(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0}, "add wrap");
        op4(16'h0000, 16'h0001, 1'b1, {16'hFFFF, 1'b0, 1'b0}, "sub borrow");
        op4(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b1, 1'b1}, "sub ovf");

        // start pulse two cycles into RUN must be dropped
        s4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; o4 = 1'b0;
        step;
        s4 = 1'b0;
        step;
        step;
        s4 = 1'b1; a4 = 16'hFFFF; b4 = 16'h0001; o4 = 1'b1;
        step;
        s4 = 1'b0;
        nd   = 0;
        seen = '0;
        for (int k = 0; k < 10; k++) begin
            step;
            if (done4) begin
                nd++;
                seen = {res4, cout4, ov4};
            end
        end
        chk("ignore ndone", 64'(nd), 64'(1));
        chk("ignore res", 64'(seen), 64'({16'h3333, 1'b0, 1'b0}));

        // start held high: one operation every 6 cycles
        s4 = 1'b1; a4 = 16'h0001; b4 = 16'h0001; o4 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step;
            if (done4) begin
                q.push_back(i);
                chk("hold res", 64'({res4, cout4, ov4}),
                    64'({16'h0002, 1'b0, 1'b0}));
            end
        end
        s4 = 1'b0;
        chk("hold ndone", 64'(q.size()), 64'(3));
        if (q.size() == 3) begin
            chk("hold gap1", 64'(q[1] - q[0]), 64'(6));
            chk("hold gap2", 64'(q[2] - q[1]), 64'(6));
        end
        for (int k = 0; k < 12 && busy4; k++) step;
        chk("hold drain", 64'(busy4), 64'(0));

        op4(16'h1234, 16'h1234, 1'b1, {16'h0000, 1'b1, 1'b0}, "sub eq");

        // asynchronous reset with idx=2 in flight
        s4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555; o4 = 1'b0;
        step;
        s4 = 1'b0;
        step;
        step;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", 64'(busy4), 64'(0));
        chk("midrst done", 64'(done4), 64'(0));
        chk("midrst out", 64'({res4, cout4, ov4}), 64'(0));
        step;
        step;
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            step;
            if (done4) nd++;
        end
        chk("midrst nodone", 64'(nd), 64'(0));
        chk("midrst idle", 64'(busy4), 64'(0));
        op4(16'h00FF, 16'h0001, 1'b0, {16'h0100, 1'b0, 1'b0}, "post rst");

        for (int n = 0; n < 1000; n++) begin
            ra2 = 8'($urandom());  rb2 = 8'($urandom());  ro2 = 1'($urandom());
            ra4 = 16'($urandom()); rb4 = 16'($urandom()); ro4 = 1'($urandom());
            ra8 = $urandom();      rb8 = $urandom();      ro8 = 1'($urandom());
            a2 = ra2; b2 = rb2; o2 = ro2; s2 = 1'b1;
            a4 = ra4; b4 = rb4; o4 = ro4; s4 = 1'b1;
            a8 = ra8; b8 = rb8; o8 = ro8; s8 = 1'b1;
            step;
            s2 = 1'b0; s4 = 1'b0; s8 = 1'b0;
            a2 = ~ra2; a4 = ~ra4; a8 = ~ra8;
            g2 = 1'b0; g4 = 1'b0; g8 = 1'b0;
            for (int k = 0; k < 14 && !(g2 && g4 && g8); k++) begin
                step;
                if (done2 && !g2) begin
                    g2 = 1'b1;
                    chk("rnd n2", 64'({res2, cout2, ov2}),
                        model(8, 32'(ra2), 32'(rb2), ro2));
                end
                if (done4 && !g4) begin
                    g4 = 1'b1;
                    chk("rnd n4", 64'({res4, cout4, ov4}),
                        model(16, 32'(ra4), 32'(rb4), ro4));
                end
                if (done8 && !g8) begin
                    g8 = 1'b1;
                    chk("rnd n8", 64'({res8, cout8, ov8}),
                        model(32, ra8, rb8, ro8));
                end
            end
            chk("rnd all done", 64'({g2, g4, g8}), 64'(3'b111));
            step;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
